// File: rtl/snd_mix_sched_if.sv
// snd_mix_sched_if: bus between the audio mixer/scheduler and its environment.
//   Source side : src_l/src_r (packed, source k at [k]), vol (9-bit gain per source),
//                 src_en, sat_clr.
//   Sound side  : snd_clk strobe, snd_phase, snd_next_sample, mixed snd_l/snd_r,
//                 sticky sat_l/sat_r, mix_busy.
// master = the block feeding sources and consuming the mix, slave = snd_mix_sched.
interface snd_mix_sched_if #(parameter int SRC_NUM = 4);
  logic        [SRC_NUM-1:0][15:0] src_l;
  logic        [SRC_NUM-1:0][15:0] src_r;
  logic        [SRC_NUM-1:0][8:0]  vol;
  logic        [SRC_NUM-1:0]       src_en;
  logic                            sat_clr;
  logic                            snd_clk;
  logic        [8:0]               snd_phase;
  logic                            snd_next_sample;
  logic signed [15:0]              snd_l;
  logic signed [15:0]              snd_r;
  logic                            sat_l;
  logic                            sat_r;
  logic                            mix_busy;

  modport master (
    output src_l, src_r, vol, src_en, sat_clr,
    input  snd_clk, snd_phase, snd_next_sample, snd_l, snd_r, sat_l, sat_r, mix_busy
  );

  modport slave (
    input  src_l, src_r, vol, src_en, sat_clr,
    output snd_clk, snd_phase, snd_next_sample, snd_l, snd_r, sat_l, sat_r, mix_busy
  );
endinterface

// File: rtl/snd_mix_sched.sv
// snd_mix_sched: sound timing generator and per-frame stereo mixer.
//   clk, rst_n : system clock, asynchronous active-low reset.
//   bus        : snd_mix_sched_if slave port (sources, gains, enables, sat_clr in;
//                snd_clk, snd_phase, snd_next_sample, snd_l/r, sat_l/r, mix_busy out).
// A fractional divider makes the snd_clk strobe; 512 strobes form one frame. At each
// frame boundary the sources are snapshotted and mixed with one shared multiplier,
// one product per cycle (src0 L, src0 R, src1 L, ...), then clamped to 16 bits.
module snd_mix_sched #(
  parameter int SRC_NUM = 4,
  parameter int DIV_NUM = 1,
  parameter int DIV_DEN = 4
) (
  input logic             clk,
  input logic             rst_n,
  snd_mix_sched_if.slave  bus
);

  localparam int SLOT_W = $clog2(2*SRC_NUM) + 1;
  localparam int IDX_W  = SLOT_W - 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(2*SRC_NUM - 1);
  localparam logic [24:0] NUM25 = 25'(DIV_NUM);
  localparam logic [24:0] DEN25 = 25'(DIV_DEN);

  typedef enum logic [1:0] {S_IDLE, S_CAPT, S_MAC, S_SAT} state_t;

  // ---------------- fractional divider + phase ----------------
  logic [23:0] acc_q;
  logic [24:0] acc_sum;
  logic        snd_clk_q;
  logic [8:0]  phase_q;
  logic        next_sample;

  // One extra bit so acc+DIV_NUM cannot wrap before the compare.
  assign acc_sum = {1'b0, acc_q} + NUM25;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      snd_clk_q <= 1'b0;
      phase_q   <= '0;
    end else begin
      if (acc_sum >= DEN25) begin
        acc_q     <= 24'(acc_sum - DEN25);
        snd_clk_q <= 1'b1;
      end else begin
        acc_q     <= acc_sum[23:0];
        snd_clk_q <= 1'b0;
      end
      if (snd_clk_q) phase_q <= phase_q + 9'd1;
    end
  end

  assign next_sample = snd_clk_q & (phase_q == 9'd511);

  // ---------------- per-source gain clamp ----------------
  logic [SRC_NUM-1:0][8:0] vol_clamp;

  for (genvar k = 0; k < SRC_NUM; k++) begin : g_vol
    assign vol_clamp[k] = (bus.vol[k] > 9'd256) ? 9'd256 : bus.vol[k];
  end

  // ---------------- mixer datapath ----------------
  state_t                   state_q;
  logic [SLOT_W-1:0]        slot_q;
  logic [SRC_NUM-1:0][15:0] sh_l_q, sh_r_q;
  logic [SRC_NUM-1:0][8:0]  sh_vol_q;
  logic [SRC_NUM-1:0]       sh_en_q;
  logic signed [20:0]       mac_l_q, mac_r_q;
  logic signed [15:0]       snd_l_q, snd_r_q;
  logic                     sat_l_q, sat_r_q;

  logic [IDX_W-1:0]   src_idx;
  logic signed [15:0] sel_smp;
  logic [8:0]         sel_vol;
  logic               sel_en;
  logic signed [9:0]  vol_ext;
  logic signed [25:0] prod;
  logic signed [17:0] prod_sh;
  logic signed [20:0] addend;

  // Slot bit 0 picks the channel, upper bits pick the source.
  assign src_idx = slot_q[SLOT_W-1:1];

  always_comb begin
    sel_smp = '0;
    sel_vol = '0;
    sel_en  = 1'b0;
    for (int k = 0; k < SRC_NUM; k++) begin
      if (src_idx == IDX_W'(k)) begin
        sel_smp = slot_q[0] ? sh_r_q[k] : sh_l_q[k];
        sel_vol = sh_vol_q[k];
        sel_en  = sh_en_q[k];
      end
    end
  end

  assign vol_ext = {1'b0, sel_vol};
  assign prod    = sel_smp * vol_ext;
  // Taking bits [25:8] is an arithmetic shift by 8: rounds toward -inf.
  assign prod_sh = prod[25:8];
  assign addend  = sel_en ? {{3{prod_sh[17]}}, prod_sh} : '0;

  // Output clamp
  logic signed [15:0] clamp_l, clamp_r;
  logic               clip_l, clip_r;

  always_comb begin
    clamp_l = mac_l_q[15:0];
    clip_l  = 1'b0;
    if (mac_l_q > 21'sd32767) begin
      clamp_l = 16'sh7fff;
      clip_l  = 1'b1;
    end else if (mac_l_q < -21'sd32768) begin
      clamp_l = -16'sh8000;
      clip_l  = 1'b1;
    end
    clamp_r = mac_r_q[15:0];
    clip_r  = 1'b0;
    if (mac_r_q > 21'sd32767) begin
      clamp_r = 16'sh7fff;
      clip_r  = 1'b1;
    end else if (mac_r_q < -21'sd32768) begin
      clamp_r = -16'sh8000;
      clip_r  = 1'b1;
    end
  end

  // ---------------- mixing FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      slot_q   <= '0;
      sh_l_q   <= '0;
      sh_r_q   <= '0;
      sh_vol_q <= '0;
      sh_en_q  <= '0;
      mac_l_q  <= '0;
      mac_r_q  <= '0;
      snd_l_q  <= '0;
      snd_r_q  <= '0;
      sat_l_q  <= 1'b0;
      sat_r_q  <= 1'b0;
    end else begin
      // A clip in the SAT cycle beats a simultaneous clear.
      sat_l_q <= (sat_l_q & ~bus.sat_clr) | ((state_q == S_SAT) & clip_l);
      sat_r_q <= (sat_r_q & ~bus.sat_clr) | ((state_q == S_SAT) & clip_r);
      case (state_q)
        S_IDLE: if (next_sample) state_q <= S_CAPT;
        S_CAPT: begin
          sh_l_q   <= bus.src_l;
          sh_r_q   <= bus.src_r;
          sh_vol_q <= vol_clamp;
          sh_en_q  <= bus.src_en;
          mac_l_q  <= '0;
          mac_r_q  <= '0;
          slot_q   <= '0;
          state_q  <= S_MAC;
        end
        S_MAC: begin
          if (slot_q[0]) mac_r_q <= mac_r_q + addend;
          else           mac_l_q <= mac_l_q + addend;
          slot_q <= slot_q + 1'b1;
          if (slot_q == LAST_SLOT) state_q <= S_SAT;
        end
        S_SAT: begin
          snd_l_q <= clamp_l;
          snd_r_q <= clamp_r;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.snd_clk         = snd_clk_q;
  assign bus.snd_phase       = phase_q;
  assign bus.snd_next_sample = next_sample;
  assign bus.snd_l           = snd_l_q;
  assign bus.snd_r           = snd_r_q;
  assign bus.sat_l           = sat_l_q;
  assign bus.sat_r           = sat_r_q;
  assign bus.mix_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_snd_mix_sched.sv
// Directed bench for snd_mix_sched: a 4-source DUT at DIV 1/4 for frame timing and
// mixing, and a 1-source DUT at DIV 3/7 for the fractional divider rate/spacing.
module tb_snd_mix_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  snd_mix_sched_if #(.SRC_NUM(4)) b();
  snd_mix_sched_if #(.SRC_NUM(1)) b2();

  snd_mix_sched #(.SRC_NUM(4), .DIV_NUM(1), .DIV_DEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b.slave)
  );

  snd_mix_sched #(.SRC_NUM(1), .DIV_NUM(3), .DIV_DEN(7)) dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(b2.slave)
  );

  // A frame boundary may never land while a mix is still running.
  always @(negedge clk)
    if (rst_n) assert (!(b.snd_next_sample && b.mix_busy))
      else $error("snd_next_sample while mix_busy");

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_src(input int k, input logic signed [15:0] l,
                         input logic signed [15:0] r, input logic [8:0] v);
    b.src_l[k] = l;
    b.src_r[k] = r;
    b.vol[k]   = v;
  endtask

  task automatic pulse_clr;
    b.sat_clr = 1'b1;
    step(1);
    b.sat_clr = 1'b0;
  endtask

  // Wait (bounded) for the frame strobe, sampled on the falling edge.
  task automatic wait_nxt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (b.snd_next_sample) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL wait_nxt: no snd_next_sample within 3000 clk");
    end
  endtask

  // Runs one frame: returns snd_l just before SAT lands (cycle T+10), the result at
  // T+11, and the number of busy cycles seen. Optionally holds sat_clr in the SAT cycle.
  task automatic run_frame(input bit clr_at_sat, output logic signed [15:0] pre_l,
                           output logic signed [15:0] l, output logic signed [15:0] r,
                           output int busy_cnt);
    bit ok;
    busy_cnt = 0;
    pre_l = 'x; l = 'x; r = 'x;
    wait_nxt(ok);
    if (ok) begin
      for (int i = 1; i <= 11; i++) begin
        @(negedge clk);
        if (b.mix_busy) busy_cnt++;
        if (i == 10) begin
          pre_l = b.snd_l;
          if (clr_at_sat) b.sat_clr = 1'b1;
        end
      end
      b.sat_clr = 1'b0;
      l = b.snd_l;
      r = b.snd_r;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(3);
    checks++;
    if ({b.snd_clk, b.snd_next_sample, b.mix_busy} !== 3'b000) begin
      failures++; $display("FAIL reset_strobes: got %b want 000",
                           {b.snd_clk, b.snd_next_sample, b.mix_busy});
    end
    checks++;
    if (b.snd_phase !== 9'd0) begin
      failures++; $display("FAIL reset_phase: got %0d want 0", b.snd_phase);
    end
    checks++;
    if ({b.snd_l, b.snd_r, b.sat_l, b.sat_r} !== 34'd0) begin
      failures++; $display("FAIL reset_mix: got l=%0d r=%0d sat=%b%b want 0",
                           b.snd_l, b.snd_r, b.sat_l, b.sat_r);
    end
  endtask

  task automatic test_frame_timing;
    int cyc = 0, nstb = 0, bad = 0;
    bit seen = 1'b0;
    rst_n = 1'b1;
    for (int i = 1; i <= 2100; i++) begin
      @(negedge clk);
      cyc = i;
      if (b.snd_clk) begin
        nstb++;
        if (cyc != 4 * nstb) bad++;
      end
      if (b.snd_next_sample) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL first_nxt: got none want strobe by clk 2048");
    end
    checks++;
    if (nstb != 512 || cyc != 2048) begin
      failures++; $display("FAIL first_nxt_pos: got strobe %0d clk %0d want 512/2048", nstb, cyc);
    end
    checks++;
    if (b.snd_phase !== 9'd511) begin
      failures++; $display("FAIL nxt_phase: got %0d want 511", b.snd_phase);
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL strobe_spacing4: got %0d off-grid strobes want 0", bad);
    end
    step(1);
    checks++;
    if (b.snd_phase !== 9'd0 || b.snd_clk !== 1'b0) begin
      failures++; $display("FAIL phase_wrap: got phase %0d clk %b want 0/0", b.snd_phase, b.snd_clk);
    end
    step(3);
    checks++;
    if (b.snd_clk !== 1'b1 || b.snd_phase !== 9'd0) begin
      failures++; $display("FAIL next_strobe: got clk %b phase %0d want 1/0", b.snd_clk, b.snd_phase);
    end
  endtask

  task automatic test_frac_div;
    int cnt = 0, bad = 0, last = -1;
    @(negedge clk);
    rst2_n = 1'b1;
    for (int i = 1; i <= 7000; i++) begin
      @(negedge clk);
      if (b2.snd_clk) begin
        cnt++;
        if (last >= 0 && (i - last < 2 || i - last > 3)) bad++;
        last = i;
      end
    end
    checks++;
    if (cnt != 3000) begin
      failures++; $display("FAIL frac_count: got %0d want 3000", cnt);
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL frac_spacing: got %0d bad gaps want 0", bad);
    end
  endtask

  task automatic test_mix_basic;
    logic signed [15:0] pre, l, r;
    int busy;
    set_src(0, 16'sd1000, -16'sd1000, 9'd256);
    set_src(1, 16'sd500, 16'sd0, 9'd128);
    set_src(2, 16'sd7777, 16'sd7777, 9'd256);
    set_src(3, -16'sd3000, 16'sd1234, 9'd200);
    b.src_en = 4'b0011;
    run_frame(1'b0, pre, l, r, busy);
    checks++;
    if (busy != 10) begin
      failures++; $display("FAIL busy_len: got %0d want 10", busy);
    end
    checks++;
    if (pre !== 16'sd0) begin
      failures++; $display("FAIL hold_before_sat: got %0d want 0", pre);
    end
    checks++;
    if (l !== 16'sd1250 || r !== -16'sd1000) begin
      failures++; $display("FAIL mix_basic: got l=%0d r=%0d want 1250/-1000", l, r);
    end
  endtask

  task automatic test_saturation;
    logic signed [15:0] pre, l, r;
    int busy;
    for (int k = 0; k < 4; k++) set_src(k, 16'sd20000, 16'sd0, 9'd256);
    b.src_en = 4'b1111;
    run_frame(1'b0, pre, l, r, busy);
    checks++;
    if (l !== 16'sd32767 || b.sat_l !== 1'b1 || b.sat_r !== 1'b0) begin
      failures++; $display("FAIL sat_pos: got l=%0d sat=%b%b want 32767 sat=10", l, b.sat_l, b.sat_r);
    end
    pulse_clr();
    checks++;
    if (b.sat_l !== 1'b0) begin
      failures++; $display("FAIL sat_clr: got %b want 0", b.sat_l);
    end
    for (int k = 0; k < 4; k++) set_src(k, 16'sd100, 16'sd0, 9'd256);
    run_frame(1'b0, pre, l, r, busy);
    checks++;
    if (l !== 16'sd400 || b.sat_l !== 1'b0) begin
      failures++; $display("FAIL no_clip: got l=%0d sat_l=%b want 400/0", l, b.sat_l);
    end
    for (int k = 0; k < 4; k++) set_src(k, -16'sd20000, 16'sd9000, 9'd256);
    run_frame(1'b1, pre, l, r, busy);
    checks++;
    if (l !== -16'sd32768 || r !== 16'sd32767) begin
      failures++; $display("FAIL sat_neg: got l=%0d r=%0d want -32768/32767", l, r);
    end
    checks++;
    if (b.sat_l !== 1'b1 || b.sat_r !== 1'b1) begin
      failures++; $display("FAIL sat_wins_clr: got %b%b want 11", b.sat_l, b.sat_r);
    end
  endtask

  task automatic test_vol_clamp;
    logic signed [15:0] pre, l, r;
    int busy;
    pulse_clr();
    set_src(0, -16'sd4, 16'sd0, 9'd300);
    set_src(1, 16'sd0, -16'sd1, 9'd1);
    set_src(2, 16'sd30000, 16'sd30000, 9'd256);
    set_src(3, 16'sd30000, 16'sd30000, 9'd256);
    b.src_en = 4'b0011;
    run_frame(1'b0, pre, l, r, busy);
    checks++;
    if (l !== -16'sd4 || r !== -16'sd1) begin
      failures++; $display("FAIL vol_clamp_floor: got l=%0d r=%0d want -4/-1", l, r);
    end
    checks++;
    if (b.sat_l !== 1'b0 || b.sat_r !== 1'b0) begin
      failures++; $display("FAIL sat_after_clr: got %b%b want 00", b.sat_l, b.sat_r);
    end
  endtask

  task automatic test_snapshot;
    logic signed [15:0] pre, l, r;
    int busy;
    bit ok;
    set_src(0, 16'sd1000, -16'sd2, 9'd256);
    b.src_en = 4'b0001;
    wait_nxt(ok);
    step(3);
    b.src_l[0] = -16'sd5000;
    step(8);
    checks++;
    if (b.snd_l !== 16'sd1000 || b.snd_r !== -16'sd2) begin
      failures++; $display("FAIL snapshot: got l=%0d r=%0d want 1000/-2", b.snd_l, b.snd_r);
    end
    run_frame(1'b0, pre, l, r, busy);
    checks++;
    if (l !== -16'sd5000) begin
      failures++; $display("FAIL next_frame_src: got %0d want -5000", l);
    end
  endtask

  task automatic test_reset_mid_mac;
    bit ok;
    wait_nxt(ok);
    step(4);
    rst_n = 1'b0;
    #1;
    checks++;
    if (b.mix_busy !== 1'b0 || b.snd_l !== 16'sd0 || b.snd_r !== 16'sd0) begin
      failures++; $display("FAIL reset_mac: got busy=%b l=%0d r=%0d want 0/0/0",
                           b.mix_busy, b.snd_l, b.snd_r);
    end
    checks++;
    if (b.snd_phase !== 9'd0 || b.snd_clk !== 1'b0) begin
      failures++; $display("FAIL reset_mac_timing: got phase %0d clk %b want 0/0",
                           b.snd_phase, b.snd_clk);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(4);
    checks++;
    if (b.snd_clk !== 1'b1 || b.snd_phase !== 9'd0 || b.mix_busy !== 1'b0) begin
      failures++; $display("FAIL restart: got clk %b phase %0d busy %b want 1/0/0",
                           b.snd_clk, b.snd_phase, b.mix_busy);
    end
  endtask

  initial begin
    b.src_l = '0; b.src_r = '0; b.vol = '0; b.src_en = '0; b.sat_clr = 1'b0;
    b2.src_l = '0; b2.src_r = '0; b2.vol = '0; b2.src_en = '0; b2.sat_clr = 1'b0;
    test_reset();
    test_frac_div();
    test_frame_timing();
    test_mix_basic();
    test_saturation();
    test_vol_clamp();
    test_snapshot();
    test_reset_mid_mac();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/snd_mix_sched.md
# snd_mix_sched

Audio frame scheduler and mixer that sits upstream of the stereo audio output path. It generates the sound timing (`snd_clk` strobe, 9-bit `snd_phase`, `snd_next_sample`) from the system clock with a fractional divider. Once per frame it mixes `SRC_NUM` stereo sources into one stereo sample, time-sharing a single signed multiplier. The outputs drive the I2S or delta-sigma output blocks directly.

## Interface
Parameters:
- `SRC_NUM`, 4: number of stereo sources; legal range 1..16.
- `DIV_NUM`, 1: fractional divider numerator; requires DIV_NUM ≤ DIV_DEN.
- `DIV_DEN`, 4: fractional divider denominator (24-bit max).

Ports:
- `clk`, in, 1: system clock. One clock domain.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `src_l`, in, 16*SRC_NUM: packed signed left samples; source k occupies [16k+15:16k].
- `src_r`, in, 16*SRC_NUM: packed signed right samples, same packing as `src_l`.
- `vol`, in, 9*SRC_NUM: per-source unsigned gain; 256 = unity; values above 256 are clamped to 256.
- `src_en`, in, SRC_NUM: per-source enable; a disabled source contributes 0.
- `sat_clr`, in, 1: clears the sticky saturation flags.
- `snd_clk`, out, 1: one-`clk` strobe, average rate clk*DIV_NUM/DIV_DEN.
- `snd_phase`, out, 9: frame phase counter.
- `snd_next_sample`, out, 1: frame boundary strobe.
- `snd_l`, out, 16: signed mixed left sample.
- `snd_r`, out, 16: signed mixed right sample.
- `sat_l`, out, 1: sticky flag, set when the left mix clipped.
- `sat_r`, out, 1: sticky flag, set when the right mix clipped.
- `mix_busy`, out, 1: high while the mixing FSM is not in IDLE.

## Operation
Fractional divider:
- 24-bit accumulator `acc`.
- Each clk: if acc+DIV_NUM ≥ DIV_DEN, then acc ← acc+DIV_NUM−DIV_DEN and `snd_clk`=1 next cycle. Otherwise acc ← acc+DIV_NUM and `snd_clk`=0.
- DIV_NUM=0 gives no strobes. DIV_NUM=DIV_DEN gives `snd_clk` high every cycle.

Phase counter:
- `snd_phase` increments by 1 mod 512 on each cycle where `snd_clk`=1.
- `snd_next_sample` = `snd_clk` & (`snd_phase`==511), combinational from registers. `snd_phase` reads 0 on the following cycle.

Mixing FSM, states IDLE → CAPT → MAC → SAT → IDLE:
- IDLE: on `snd_next_sample`, go to CAPT.
- CAPT: snapshot `src_l`, `src_r`, clamped `vol` and `src_en` into shadow registers. Clear the left and right accumulators. Slot index ← 0.
- MAC: 2*SRC_NUM cycles, one multiply per cycle. Order is src0 L, src0 R, src1 L, … src(N−1) R.
  - Product: s16 × u9 → s26, then arithmetic shift right by 8 → s18.
  - The product is added to a 21-bit signed accumulator; add 0 if the source is disabled.
- SAT: clamp each accumulator to [−32768, 32767] and register it into `snd_l`/`snd_r`. Set `sat_l`/`sat_r` if clamping occurred. Return to IDLE.
- `mix_busy` = (state ≠ IDLE).

Flag and hazard rules:
- `sat_clr` clears the flags; a new saturation in the same cycle wins (flag stays 1).
- `snd_next_sample` while `mix_busy`=1 cannot occur in legal configurations (512 strobes ≥ 512 clk > 2*16+2). The bench asserts on it; the RTL ignores such a strobe.
- Source inputs may change at any time; only the CAPT snapshot is used.

## Timing
Reset values:
- `acc`, `snd_phase`, `snd_clk`, `snd_next_sample`, `snd_l`, `snd_r`, `sat_l`, `sat_r`, `mix_busy` are all 0.
- FSM is in IDLE.
- Reset deasserted mid-frame restarts at phase 0 with no pending mix.

Latency:
- `snd_next_sample` in cycle T → CAPT in T+1 → MAC in T+2..T+1+2N → SAT in T+2+2N.
- `snd_l`/`snd_r` are valid from T+3+2N and held until the next frame's SAT.
- Downstream latches `snd_l`/`snd_r` on its own `snd_next_sample`. Net source-to-DAC delay is therefore exactly one frame.

Outputs are registered except `snd_next_sample`. No output glitches between strobes.

## Test plan
- DIV_NUM=1, DIV_DEN=4, reset release → `snd_clk` every 4th clk; `snd_next_sample` first at `snd_clk` #512 with `snd_phase`=511; phase 0 next strobe.
- DIV_NUM=3, DIV_DEN=7, run 7000 clk → exactly 3000 `snd_clk` strobes; spacing is only 2 or 3 clk.
- SRC_NUM=4, src0 L/R=1000/−1000 at vol 256, src1 L/R=500/0 at vol 128, others disabled → `snd_l`=1250, `snd_r`=−1000 at T+11; `mix_busy` high for exactly 10 cycles.
- Four sources at +20000, vol 256 → `snd_l`=32767, `sat_l`=1. Pulse `sat_clr` in a frame without clipping → `sat_l`=0. Same test with −20000 → −32768.
- vol=300 with src=−4 → treated as 256, contributes −4. vol=1, src=−1 → −1 (arithmetic shift rounds toward −∞).
- Change `src_l` during MAC → the current result is unaffected; assert `rst_n` low during MAC → all outputs 0 immediately, FSM IDLE.
